// File: rtl/cpu_pkg.sv
// Shared definitions for the moxie core: boot address and the
// instruction-memory responder state encoding.
package cpu_pkg;

    localparam logic [31:0] BOOT_ADDRESS = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_t;

endpackage

// File: rtl/cpu_imem_ram.sv
// Instruction RAM: four byte-wide banks sharing one word index, with a
// registered read port and an independent single-byte write port.
module cpu_imem_ram #(
    parameter int DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rd_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [31:0]                    rd_data,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [1:0]                     wr_lane,
    input  logic [7:0]                     wr_byte
);

    for (genvar lane = 0; lane < 4; lane++) begin : g_bank
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] q;

        // NOTE: the storage array has no reset so it maps onto block RAM;
        // only the read register below is reset.
        always_ff @(posedge clk) begin
            if (wr_en && wr_lane == 2'(lane)) begin
                mem[wr_idx] <= wr_byte;
            end
        end

        // NOTE: non-blocking assignments make a same-edge write invisible to
        // this read, giving read-before-write behaviour.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
            end else if (rd_en) begin
                q <= mem[rd_idx];
            end
        end
    end

    // Lane 0 is the lowest byte address and lands in the top byte.
    assign rd_data = {g_bank[0].q, g_bank[1].q, g_bank[2].q, g_bank[3].q};

endmodule

// File: rtl/cpu_imem.sv
// Instruction-memory responder: accepts word fetches, answers after a fixed
// number of wait states with a big-endian word or an error flag.
module cpu_imem
    import cpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = BOOT_ADDRESS,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] data_o,
    output logic        err_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [7:0]  load_byte_i
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);
    // 33-bit bound so a window ending at the top of the address space does not wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    imem_state_t state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] addr_q;
    logic        err_q;
    logic        accept;
    logic        enter_resp;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic [31:0] ram_rdata;

    assign ready_o = (state != WAIT);
    assign ack_o   = (state == RESP);
    assign accept  = req_i && ready_o;

    // With zero wait states the RAM is read on the accept edge itself,
    // so the request address is used directly rather than the captured one.
    assign rd_addr  = (state == WAIT) ? addr_q : addr_i;
    assign rd_valid = (rd_addr[1:0] == 2'b00) && in_window(rd_addr);

    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (WS == 4'd0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WS - 4'd1;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                addr_q <= addr_i;
            end
            if (enter_resp) begin
                err_q <= !rd_valid;
            end
        end
    end

    // The RAM read register only updates on a valid response, so both
    // outputs hold their last response values between acks.
    assign err_o  = err_q;
    assign data_o = err_q ? 32'h0 : ram_rdata;

    cpu_imem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk     (clk_i),
        .rst     (rst_i),
        .rd_en   (enter_resp && rd_valid),
        .rd_idx  (word_idx(rd_addr)),
        .rd_data (ram_rdata),
        .wr_en   (load_we_i && in_window(load_addr_i)),
        .wr_idx  (word_idx(load_addr_i)),
        .wr_lane (load_addr_i[1:0]),
        .wr_byte (load_byte_i)
    );

endmodule

// File: tb/tb_cpu_imem.sv
// Directed scoreboard bench for cpu_imem with three instances that differ
// only in wait-state count (1, 0 and 3) and share reset and loader port.
module tb_cpu_imem;
    import cpu_pkg::*;

    localparam int          DEPTH    = 16;
    localparam logic [31:0] BASE     = BOOT_ADDRESS;
    localparam logic [31:0] END_ADDR = BASE + 32'(4 * DEPTH);

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        ready [3];
    logic        ack   [3];
    logic        err   [3];
    logic [31:0] data  [3];
    logic        load_we;
    logic [31:0] load_addr;
    logic [7:0]  load_byte;

    int    total = 0;
    int    bad   = 0;
    resp_t sb[$];

    always #5 clk = ~clk;

    cpu_imem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .addr_i(addr[0]),
        .ready_o(ready[0]), .ack_o(ack[0]), .data_o(data[0]), .err_o(err[0]),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_byte_i(load_byte));

    cpu_imem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .addr_i(addr[1]),
        .ready_o(ready[1]), .ack_o(ack[1]), .data_o(data[1]), .err_o(err[1]),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_byte_i(load_byte));

    cpu_imem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .addr_i(addr[2]),
        .ready_o(ready[2]), .ack_o(ack[2]), .data_o(data[2]), .err_o(err[2]),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_byte_i(load_byte));

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input int d, input string tag);
        resp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_err"}, 32'(err[d]), 32'(e.err));
            check({tag, "_data"}, data[d], e.data);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [7:0] b);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = a;
        load_byte = b;
        @(posedge clk);
        #1 load_we = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] w);
        load(a,         w[31:24]);
        load(a + 32'd1, w[23:16]);
        load(a + 32'd2, w[15:8]);
        load(a + 32'd3, w[7:0]);
    endtask

    // Single request: checks ready/ack on every cycle up to the expected
    // response, the response itself, and that ack is a one-cycle pulse.
    task automatic fetch(input int d, input logic [31:0] a, input logic e_err,
                         input logic [31:0] e_data, input string tag);
        int ws;
        ws = ws_of(d);
        @(negedge clk);
        req[d]  = 1'b1;
        addr[d] = a;
        #1 check({tag, "_ready_in"}, 32'(ready[d]), 32'd1);
        @(posedge clk);
        #1 req[d] = 1'b0;
        sb.push_back('{err: e_err, data: e_data});
        for (int k = 0; k <= ws; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("%s_ack_c%0d", tag, k), 32'(ack[d]), 32'(k == ws));
            check($sformatf("%s_ready_c%0d", tag, k), 32'(ready[d]), 32'(k == ws));
        end
        pop_check(d, tag);
        @(posedge clk);
        #1 check({tag, "_ack_pulse"}, 32'(ack[d]), 32'd0);
    endtask

    initial begin
        logic [31:0] s_addr [3];
        resp_t       s_exp  [3];

        rst       = 1'b1;
        load_we   = 1'b0;
        load_addr = '0;
        load_byte = '0;
        for (int d = 0; d < 3; d++) begin
            req[d]  = 1'b0;
            addr[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst%0d_ready", d), 32'(ready[d]), 32'd1);
            check($sformatf("rst%0d_ack", d), 32'(ack[d]), 32'd0);
            check($sformatf("rst%0d_err", d), 32'(err[d]), 32'd0);
            check($sformatf("rst%0d_data", d), data[d], 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Memory image; the two out-of-range bytes would alias onto
        // word 0 / word 15 lane 0 if the loader range check were missing.
        load_word(BASE,          32'h0102_0304);
        load_word(BASE + 32'h4,  32'h1122_3344);
        load_word(BASE + 32'h8,  32'hA5B6_C7D8);
        load_word(END_ADDR - 4,  32'hDEAD_BEEF);
        load(END_ADDR, 8'hEE);
        load(BASE - 32'd4, 8'hEE);

        fetch(0, BASE,          1'b0, 32'h0102_0304, "ld_read");
        fetch(0, END_ADDR - 4,  1'b0, 32'hDEAD_BEEF, "last_word");
        fetch(0, BASE + 32'h2,  1'b1, 32'h0,         "err_misalign");
        fetch(0, BASE - 32'h4,  1'b1, 32'h0,         "err_below");
        fetch(0, END_ADDR,      1'b1, 32'h0,         "err_above");
        fetch(2, END_ADDR,      1'b1, 32'h0,         "ws3_err_above");
        fetch(2, BASE + 32'h8,  1'b0, 32'hA5B6_C7D8, "ws3_read");

        // Zero-wait streaming: one accept and one ack per cycle.
        s_addr[0] = BASE;
        s_addr[1] = BASE + 32'h4;
        s_addr[2] = BASE + 32'h8;
        s_exp[0]  = '{err: 1'b0, data: 32'h0102_0304};
        s_exp[1]  = '{err: 1'b0, data: 32'h1122_3344};
        s_exp[2]  = '{err: 1'b0, data: 32'hA5B6_C7D8};
        @(negedge clk);
        req[1]  = 1'b1;
        addr[1] = s_addr[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            sb.push_back(s_exp[i]);
            check($sformatf("stream%0d_ready", i), 32'(ready[1]), 32'd1);
            check($sformatf("stream%0d_ack", i), 32'(ack[1]), 32'd1);
            pop_check(1, $sformatf("stream%0d", i));
            if (i < 2) addr[1] = s_addr[i + 1];
            else       req[1]  = 1'b0;
        end
        @(posedge clk);
        #1 check("stream_end_ack", 32'(ack[1]), 32'd0);

        // Collision: loader writes the word on the same edge that reads it.
        @(negedge clk);
        req[0]  = 1'b1;
        addr[0] = BASE;
        @(posedge clk);
        #1;
        req[0]    = 1'b0;
        sb.push_back('{err: 1'b0, data: 32'h0102_0304});
        load_we   = 1'b1;
        load_addr = BASE;
        load_byte = 8'hAA;
        check("coll_wait_ack", 32'(ack[0]), 32'd0);
        @(posedge clk);
        #1;
        load_we = 1'b0;
        check("coll_ack", 32'(ack[0]), 32'd1);
        pop_check(0, "coll_old");
        fetch(0, BASE, 1'b0, 32'hAA02_0304, "coll_new");

        // Reset while the three-wait-state instance is in WAIT.
        @(negedge clk);
        req[2]  = 1'b1;
        addr[2] = BASE + 32'h4;
        @(posedge clk);
        #1;
        req[2] = 1'b0;
        check("rw_ready_w0", 32'(ready[2]), 32'd0);
        @(posedge clk);
        #1;
        check("rw_ready_w1", 32'(ready[2]), 32'd0);
        rst = 1'b1;
        #1;
        check("rw_ready_now", 32'(ready[2]), 32'd1);
        check("rw_ack_now", 32'(ack[2]), 32'd0);
        check("rw_data_now", data[2], 32'd0);
        check("rw_err_now", 32'(err[2]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 check($sformatf("rw_no_ack_c%0d", k), 32'(ack[2]), 32'd0);
        end
        fetch(2, BASE + 32'h4, 1'b0, 32'h1122_3344, "rw_after");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
